// File: rtl/prodacc_pkg.sv
// Shared types and constants for the product accumulator.
package prodacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } prodacc_state_t;

  localparam int N_DEF     = 8;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 16;

  // All-ones value of a w-bit accumulator (w up to 64).
  function automatic logic [63:0] sat_max(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/prodacc_add_sat.sv
// (ACC_W+1)-bit adder with carry out; clamps on carry when PRODACC_SAT_EN is
// defined, otherwise wraps modulo 2^ACC_W.
module prodacc_add_sat
  import prodacc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int PW    = 2 * N_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [PW-1:0]    prod,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = full[ACC_W];

`ifdef PRODACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  // A clamped acc carries again on any nonzero term, so it stays at max.
  assign sum = carry ? ACC_MAX : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Group-sum accumulator for multiplier products with valid/ready in and out.
// Optional clamping on overflow: define PRODACC_SAT_EN.
module prod_accumulator
  import prodacc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  if (ACC_W < 2 * N) begin : g_bad_acc_w
    $error("ACC_W must be at least 2*N");
  end

  prodacc_state_t   state, nxt;
  logic [ACC_W-1:0] acc, add_sum;
  logic [CNT_W-1:0] count;
  logic             ovf, carry, accept;

  prodacc_add_sat #(.ACC_W(ACC_W), .PW(2*N)) u_add (
    .acc   (acc),
    .prod  (in_prod),
    .sum   (add_sum),
    .carry (carry)
  );

  // Handshake outputs depend on the state register only.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  always_comb begin
    nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) nxt = in_last ? DONE : ACCUM;
      DONE:        if (out_ready) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        if (state == IDLE) begin
          acc   <= ACC_W'(in_prod);
          count <= CNT_W'(1);
          ovf   <= 1'b0;
        end else begin
          acc   <= add_sum;
          count <= (&count) ? count : count + CNT_W'(1);
          ovf   <= ovf | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: vector table, scoreboard queue and
// directed sequences for backpressure, overflow and reset.
module tb_prod_accumulator;

  localparam int N = 8, ACC_W = 24, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [2*N-1:0]   in_prod;
  logic             out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  int checks = 0, passed = 0;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  typedef struct {
    int               len;
    logic [2*N-1:0]   prod [3];
    int               gap;
    res_t             exp;
  } vec_t;

  res_t sb [$];

  prod_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sb_sum",   32'(out_sum),   32'(e.sum));
        chk("sb_count", 32'(out_count), 32'(e.count));
        chk("sb_ovf",   32'(out_ovf),   32'(e.ovf));
      end
    end
  end

  // Drive one beat; returns #1 after the edge on which it was accepted.
  task automatic beat(input logic [2*N-1:0] p, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_sum"},   32'(out_sum),   32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
    chk({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
  endtask

  vec_t vecs [4];

  initial begin
    logic [ACC_W-1:0] held_sum;
    res_t r;
    int t;

    vecs[0] = '{len:1, prod:'{16'h1234, 16'h0, 16'h0}, gap:0, exp:'{24'h001234, 16'd1, 1'b0}};
    vecs[1] = '{len:3, prod:'{16'h0006, 16'h000F, 16'hFE01}, gap:1, exp:'{24'h00FE16, 16'd3, 1'b0}};
    vecs[2] = '{len:2, prod:'{16'hFFFF, 16'h0001, 16'h0}, gap:0, exp:'{24'h010000, 16'd2, 1'b0}};
    vecs[3] = '{len:3, prod:'{16'h0000, 16'h0000, 16'h0000}, gap:2, exp:'{24'h000000, 16'd3, 1'b0}};

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check_reset_state("reset");

    // Table-driven groups with out_ready held high.
    for (int v = 0; v < 4; v++) begin
      sb.push_back(vecs[v].exp);
      for (int b = 0; b < vecs[v].len; b++) begin
        beat(vecs[v].prod[b], b == vecs[v].len - 1);
        if (b == vecs[v].len - 1) chk($sformatf("vec%0d_latency", v), 32'(out_valid), 32'd1);
        else idle(vecs[v].gap);
      end
      idle(1);
      chk($sformatf("vec%0d_back_to_idle", v), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held for 5 cycles, beats refused meanwhile.
    out_ready = 1'b0;
    sb.push_back('{24'h0000AB, 16'd1, 1'b0});
    beat(16'h00AB, 1'b1);
    in_valid = 1'b1; in_prod = 16'h7777; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
      chk($sformatf("bp%0d_out_sum", c),   32'(out_sum),   32'h0000AB);
      idle(1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Overflow: 259 back-to-back beats of 0xFE01.
`ifdef PRODACC_SAT_EN
    r = '{24'hFFFFFF, 16'd259, 1'b1};
`else
    r = '{24'h00FB03, 16'd259, 1'b1};
`endif
    sb.push_back(r);
    for (int b = 0; b < 259; b++) beat(16'hFE01, b == 258);
    idle(1);

    // Reset mid-group discards the partial sum.
    beat(16'h0010, 1'b0);
    beat(16'h0010, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_state("midrst");
    sb.push_back('{24'h000001, 16'd1, 1'b0});
    beat(16'h0001, 1'b1);
    idle(1);

    // Reset coinciding with the output handshake: result is dropped.
    beat(16'h0055, 1'b1);
    chk("rsths_out_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_state("rsths");

    t = 0;
    while (sb.size() != 0 && t < 50) begin idle(1); t++; end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Streaming accumulator that sits directly downstream of the unsigned N×N combinational multiplier and consumes its 2N-bit products. It sums a group of products, delimited by a `last` flag, into a wider accumulator. It then presents the group sum, term count and overflow flag on a registered valid/ready output. Together the two blocks form the datapath's multiply-accumulate (dot-product) stage.

## Interface
- `N`, 8: operand width of the upstream multiplier; product width is 2N.
- `ACC_W`, 24: accumulator width; legal range ACC_W ≥ 2N.
- `CNT_W`, 16: term-counter width.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_prod`/`in_last` valid.
- `in_ready` out 1: block accepts a beat; a beat transfers when `in_valid & in_ready`.
- `in_prod` in 2N: unsigned product from the multiplier.
- `in_last` in 1: this beat ends the group.
- `out_valid` out 1: group result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out ACC_W: group sum, zero-extended.
- `out_count` out CNT_W: number of beats in the group.
- `out_ovf` out 1: sticky; the group sum exceeded 2^ACC_W−1.

## Operation
- FSM with states IDLE, ACCUM and DONE.
- IDLE: `in_ready`=1. On an accepted beat, acc←`in_prod`, count←1, ovf←0. If `in_last`=1 go to DONE, else go to ACCUM.
- ACCUM: `in_ready`=1. On an accepted beat, acc←acc+`in_prod` computed in ACC_W+1 bits, count←count+1 (saturating at 2^CNT_W−1), and ovf←ovf | carry. If `in_last`=1 go to DONE. Without an accepted beat, state is held.
- DONE: `in_ready`=0 and `out_valid`=1. `out_sum`, `out_count` and `out_ovf` are held stable until `out_valid & out_ready`. The block then goes to IDLE and `out_valid` drops.
- `out_sum`, `out_count` and `out_ovf` are driven straight from the acc, count and ovf registers.
- Beats are never accepted in DONE; groups never overlap.
- Gaps (`in_valid`=0) inside a group have no effect.
- Reset mid-operation: `rst` has priority over all events in the same cycle. The next cycle is IDLE with acc=0, count=0, ovf=0 and `out_valid`=0. Any partial group is discarded.
- Reset values: `out_valid`=0, `in_ready`=1, `out_sum`=0, `out_count`=0, `out_ovf`=0.

## Timing
- Input throughput is one beat per cycle within a group.
- Latency: `out_valid` rises in the cycle after the accepted `in_last` beat.
- Minimum group period is the group length + 1 cycle, achieved when `out_ready` is held at 1.
- `in_ready` is a function of state only, with no combinational path from `in_valid` or `out_ready`.
- The output handshake follows the standard valid/ready rule: once `out_valid` is asserted it stays asserted, with data stable, until accepted.

## Configuration
- Macro `PRODACC_SAT_EN`.
- Defined: on overflow, acc clamps to 2^ACC_W−1 and stays there for the rest of the group. `out_ovf`=1.
- Undefined: acc wraps modulo 2^ACC_W. `out_ovf`=1 still flags the wrap.

## Structure
- Shared package `prodacc_pkg` holds:
  - the state enum `prodacc_state_t` (IDLE, ACCUM, DONE);
  - the default-width localparams;
  - the saturation constant function.
- One sub-module: `prodacc_add_sat`, a combinational (ACC_W+1)-bit adder producing the carry and the clamped or wrapped sum. The `PRODACC_SAT_EN` choice lives inside it.
- FSM and registers stay in the top level.

## Test plan
All scenarios use N=8, ACC_W=24, CNT_W=16.
- Single beat: `in_prod`=0x1234 with `in_last`=1 → next cycle `out_valid`=1, `out_sum`=0x001234, `out_count`=1, `out_ovf`=0.
- Group 0x0006, 0x000F, 0xFE01 (last), with one idle cycle between beats → `out_sum`=0x00FE16, `out_count`=3.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable and `in_ready`=0 throughout. On the handshake → IDLE next cycle with `in_ready`=1.
- Overflow: 259 beats of 0xFE01 → `out_count`=259 and `out_ovf`=1. `out_sum`=0x00FB03 without `PRODACC_SAT_EN`; 0xFFFFFF with it.
- Reset mid-group: 2 beats of 0x0010, then `rst` for 1 cycle → `out_valid`=0 and IDLE. A new beat 0x0001 with `in_last`=1 → `out_sum`=0x000001, `out_count`=1.
- Reset and handshake coincide: `rst`=1 in the same cycle as `out_valid & out_ready` → next cycle all outputs at their reset values.
